// File: rtl/serializer_pkg.sv
// Shared types and defaults for the electrode configuration serializer.
package serializer_pkg;

  localparam int N_ELECTRODES_DEFAULT = 55;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  // Bit counter width for an n-bit frame; clamped so a degenerate n still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Frame bit counter: counts up to TERMINAL and holds there until cleared.
module ser_bit_counter #(
  parameter int TERMINAL = 54,
  parameter int WIDTH    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count;

  // Saturates at the terminal value so a late enable can never wrap the count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TERM_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == TERM_VAL);

endmodule

// File: rtl/serializer_mod.sv
// Parallel-to-serial electrode configuration shifter with registered outputs.
// Define SERIALIZER_LSB_FIRST_EN to emit bit [0] first instead of bit [N-1].
module serializer_mod
  import serializer_pkg::*;
#(
  parameter int N_ELECTRODES = N_ELECTRODES_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_ELECTRODES-1:0] electr_config_in,
  input  logic                    enable_desp,
  output logic                    serial_out,
  output logic                    enable_config,
  output logic                    sr_finish
);

  localparam int CNT_W = cnt_width(N_ELECTRODES);

  ser_state_t              state;
  ser_state_t              state_next;
  logic [N_ELECTRODES-1:0] shift_reg;
  logic [N_ELECTRODES-1:0] shift_next;
  logic                    serial_next;
  logic                    enable_next;
  logic                    finish_next;
  logic                    cnt_clear;
  logic                    cnt_enable;
  logic                    cnt_terminal;

`ifdef SERIALIZER_LSB_FIRST_EN
  function automatic logic head_bit(input logic [N_ELECTRODES-1:0] w);
    return w[0];
  endfunction

  function automatic logic [N_ELECTRODES-1:0] advance(input logic [N_ELECTRODES-1:0] w);
    return w >> 1;
  endfunction
`else
  function automatic logic head_bit(input logic [N_ELECTRODES-1:0] w);
    return w[N_ELECTRODES-1];
  endfunction

  function automatic logic [N_ELECTRODES-1:0] advance(input logic [N_ELECTRODES-1:0] w);
    return w << 1;
  endfunction
`endif

  ser_bit_counter #(
    .TERMINAL (N_ELECTRODES - 1),
    .WIDTH    (CNT_W)
  ) u_bit_counter (
    .clk      (CLK),
    .rst      (RST),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // The first bit is presented on the capture edge, so the counter trails the output by one bit.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    serial_next = 1'b0;
    enable_next = 1'b0;
    finish_next = 1'b0;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable_desp) begin
          state_next  = SHIFT;
          shift_next  = electr_config_in;
          serial_next = head_bit(electr_config_in);
          enable_next = 1'b1;
          cnt_clear   = 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_terminal) begin
          state_next  = DONE;
          shift_next  = '0;
          finish_next = 1'b1;
        end else begin
          cnt_enable  = 1'b1;
          shift_next  = advance(shift_reg);
          serial_next = head_bit(advance(shift_reg));
          enable_next = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      shift_reg     <= '0;
      serial_out    <= 1'b0;
      enable_config <= 1'b0;
      sr_finish     <= 1'b0;
    end else begin
      state         <= state_next;
      shift_reg     <= shift_next;
      serial_out    <= serial_next;
      enable_config <= enable_next;
      sr_finish     <= finish_next;
    end
  end

endmodule

// File: tb/tb_serializer_mod.sv
// Self-checking bench for serializer_mod: directed scenarios plus random traffic against a frame-timing model.
// Honours SERIALIZER_LSB_FIRST_EN so the model follows whichever bit order the DUT was built with.
module tb_serializer_mod;

  localparam int N = 55;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [N-1:0] electr_config_in = '0;
  logic         enable_desp = 1'b0;
  logic         serial_out;
  logic         enable_config;
  logic         sr_finish;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: a frame is a start edge plus a count of edges since it.
  bit           m_active = 1'b0;
  int           m_k = 0;
  logic [N-1:0] m_word = '0;

  int seen_enable = 0;
  int seen_ones = 0;
  int seen_finish = 0;

  serializer_mod #(.N_ELECTRODES(N)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .electr_config_in (electr_config_in),
    .enable_desp      (enable_desp),
    .serial_out       (serial_out),
    .enable_config    (enable_config),
    .sr_finish        (sr_finish)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    for (int b = 0; b < N; b++) w[b] = 1'($urandom_range(1, 0));
    return w;
  endfunction

  task automatic checkCount(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s actual=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    logic exp_serial;
    logic exp_enable;
    logic exp_finish;
    exp_serial = 1'b0;
    exp_enable = 1'b0;
    exp_finish = 1'b0;
    if (m_active && m_k < N) begin
      exp_enable = 1'b1;
`ifdef SERIALIZER_LSB_FIRST_EN
      exp_serial = m_word[m_k];
`else
      exp_serial = m_word[N-1-m_k];
`endif
    end
    if (m_active && m_k == N) exp_finish = 1'b1;

    tests_run++;
    assert (serial_out === exp_serial) else begin
      tests_failed++;
      $error("[TB] FAIL serial_out k=%0d actual=%b expected=%b", m_k, serial_out, exp_serial);
    end
    tests_run++;
    assert (enable_config === exp_enable) else begin
      tests_failed++;
      $error("[TB] FAIL enable_config k=%0d actual=%b expected=%b", m_k, enable_config, exp_enable);
    end
    tests_run++;
    assert (sr_finish === exp_finish) else begin
      tests_failed++;
      $error("[TB] FAIL sr_finish k=%0d actual=%b expected=%b", m_k, sr_finish, exp_finish);
    end

    if (enable_config === 1'b1) seen_enable++;
    if (serial_out === 1'b1) seen_ones++;
    if (sr_finish === 1'b1) seen_finish++;
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic applyStimulus(input logic rst, input logic en, input logic [N-1:0] cfg);
    RST = rst;
    enable_desp = en;
    electr_config_in = cfg;
    @(posedge CLK);
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k == N + 2) m_active = 1'b0;
    end
    if (!rst && !m_active && en) begin
      m_active = 1'b1;
      m_k = 0;
      m_word = cfg;
    end
    #1;
    checkOutput();
  endtask

  task automatic clearSeen();
    seen_enable = 0;
    seen_ones = 0;
    seen_finish = 0;
  endtask

  logic [N-1:0] word_a;
  logic [N-1:0] all_ones;
  int           start_a;
  int           start_b;

  initial begin
    all_ones = '1;

    // Reset for two cycles, with a start request during reset that must be ignored.
    applyStimulus(1'b1, 1'b0, rand_word());
    applyStimulus(1'b1, 1'b1, rand_word());
    applyStimulus(1'b0, 1'b0, '0);

    // Reference word, single-cycle start pulse, input scrambled afterwards.
    clearSeen();
    word_a = 55'h3AA55AA3FF;
    applyStimulus(1'b0, 1'b1, word_a);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0, rand_word());
    checkCount("ref_word_enable_cycles", seen_enable, N);
    checkCount("ref_word_finish_pulses", seen_finish, 1);
    checkCount("ref_word_ones", seen_ones, $countones(word_a));

    // Start held high: back-to-back frames spaced N+2 cycles apart.
    clearSeen();
    start_a = -1;
    start_b = -1;
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b0, 1'b1, all_ones);
      if (enable_config === 1'b1 && seen_enable == 1) start_a = i;
      if (enable_config === 1'b1 && seen_enable == N + 1) start_b = i;
    end
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0, all_ones);
    checkCount("held_start_ones", seen_ones, 2 * N);
    checkCount("held_start_finish_pulses", seen_finish, 2);
    checkCount("held_start_spacing", start_b - start_a, N + 2);

    // Second request mid-frame with the input zeroed must not disturb the frame.
    clearSeen();
    word_a = rand_word();
    word_a[N-1] = 1'b1;
    applyStimulus(1'b0, 1'b1, word_a);
    for (int i = 1; i < 10; i++) applyStimulus(1'b0, 1'b0, word_a);
    applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < 55; i++) applyStimulus(1'b0, 1'b0, '0);
    checkCount("midframe_request_ones", seen_ones, $countones(word_a));
    checkCount("midframe_request_finish", seen_finish, 1);

    // Reset at shift cycle 20 abandons the frame; a fresh start then runs normally.
    clearSeen();
    applyStimulus(1'b0, 1'b1, all_ones);
    for (int i = 1; i < 20; i++) applyStimulus(1'b0, 1'b0, all_ones);
    applyStimulus(1'b1, 1'b0, all_ones);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0, all_ones);
    checkCount("reset_abandon_finish", seen_finish, 0);
    checkCount("reset_abandon_enable", seen_enable, 20);
    clearSeen();
    word_a = rand_word();
    applyStimulus(1'b0, 1'b1, word_a);
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b0, rand_word());
    checkCount("post_reset_finish", seen_finish, 1);
    checkCount("post_reset_ones", seen_ones, $countones(word_a));

    // Single set bit at position 0 exposes the bit order.
    word_a = '0;
    word_a[0] = 1'b1;
    applyStimulus(1'b0, 1'b1, word_a);
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b0, '0);

    // Random traffic: sporadic starts, input churn and rare resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(199, 0) == 0),
                    ($urandom_range(9, 0) < 2),
                    rand_word());
    end
    for (int i = 0; i < N + 3; i++) applyStimulus(1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serializer_mod.md
SERIALIZER_MOD -- requirements
Module: serializer_mod

Interface
REQ-001 Parameter: N_ELECTRODES, default 55, number of configuration bits (electrodes) per frame; legal range 2..1024.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: electr_config_in  input  N_ELECTRODES  parallel electrode configuration word; sampled only at start.
REQ-005 Port: enable_desp  input  1  start request, level-sampled each cycle.
REQ-006 Port: serial_out  output  1  serial data bit.
REQ-007 Port: enable_config  output  1  high while serial_out carries a valid bit (downstream shift enable).
REQ-008 Port: sr_finish  output  1  one-cycle pulse on frame completion.

Function
REQ-009 State machine: IDLE, SHIFT, DONE; all outputs registered.
REQ-010 IDLE with enable_desp=1 at edge E: capture electr_config_in into shift register, clear bit counter, enter SHIFT.
REQ-011 SHIFT lasts exactly N_ELECTRODES cycles (edges E+1..E+N); enable_config=1 throughout.
REQ-012 Bit order MSB first: during SHIFT cycle i (i=0..N-1), serial_out = captured bit [N-1-i].
REQ-013 Counter width $clog2(N_ELECTRODES); counter reaching N-1 moves to DONE; no wrap beyond N-1.
REQ-014 DONE lasts one cycle: sr_finish=1, enable_config=0, serial_out=0; then unconditional return to IDLE.
REQ-015 Outside SHIFT, serial_out=0 and enable_config=0; sr_finish=0 outside DONE.
REQ-016 enable_desp ignored in SHIFT and DONE (no restart, no queuing); held high across DONE, it restarts from the IDLE cycle that follows.
REQ-017 Changes on electr_config_in after capture do not affect the frame in progress.
REQ-018 Minimum start-to-start spacing: N+2 cycles.

Reset
REQ-019 RST=1 at any edge, including mid-SHIFT: state IDLE, shift register and counter cleared, serial_out=0, enable_config=0, sr_finish=0; the interrupted frame is abandoned, with no sr_finish.
REQ-020 enable_desp asserted during the same edge as RST is ignored.

Configuration
REQ-021 Macro SERIALIZER_LSB_FIRST_EN: when defined, the order is LSB first (cycle i outputs bit [i]); when undefined, MSB first per REQ-012. Timing is identical in both cases.

Structure
REQ-022 Package serializer_pkg holds the state enum typedef (IDLE/SHIFT/DONE) and the default N_ELECTRODES constant.
REQ-023 One sub-module, ser_bit_counter (parameterised terminal count, clear, enable, terminal flag); the shift register and FSM stay in serializer_mod.

Verification
REQ-024 Reset: RST=1 for 2 cycles -> serial_out=0, enable_config=0, sr_finish=0.
REQ-025 Load 55'h3AA55AA3FF, 1-cycle enable_desp pulse -> enable_config high exactly 55 cycles; serial_out 0 for the first 17 cycles, then 1,1,1,0,1,0,1,0...; last 8 bits are 1; sr_finish pulses once on cycle 56 after start.
REQ-026 All-ones word, enable_desp held high for 70 cycles -> two back-to-back frames 57 cycles apart, each producing 55 ones and one sr_finish.
REQ-027 Second enable_desp pulse at SHIFT cycle 10 with the input changed to 0 -> no restart; the original word completes unchanged.
REQ-028 RST asserted at SHIFT cycle 20 -> outputs 0 on the next edge, no sr_finish; a new start afterwards serializes normally.
REQ-029 SERIALIZER_LSB_FIRST_EN defined, word 55'h1 -> serial_out=1 on the first SHIFT cycle only.
